pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline.
- Drives write-enables of the PC register, F/D latch and D/X latch, and nop-select muxes that insert bubbles into the F/D, D/X and X/M latches.
- Sequences the multi-cycle mult/div unit (start pulse, wait for ready, timeout) and counts stall cycles for performance monitoring.
- Sits beside the latches in the processor top level; purely control, no datapath storage.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 49 ++++
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared instruction-format constants for the pipeline control path.
// The decode stage imports the same opcode and field definitions.
package pipeline_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int ALUOP_LSB = 2;

    typedef enum logic {
        ST_RUN,
        ST_MD_WAIT
    } hz_state_t;

    function automatic logic [4:0] ir_field(input logic [31:0] ir, input int lsb);
        return ir[lsb +: 5];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational hazard classification of the F/D and D/X instructions:
// mult/div in D/X and load-use dependencies between D/X and F/D.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    output logic        is_mult,
    output logic        is_div,
    output logic        dx_is_lw,
    output logic        load_use
);

    logic [4:0] fd_op;
    logic [4:0] fd_rd;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic [4:0] dx_op;
    logic [4:0] dx_rd;
    logic [4:0] dx_alu;
    logic       dx_rtype;
    logic       fd_reads_rd;
    logic       unused_fields;

    assign fd_op  = ir_field(fd_ir, OPC_LSB);
    assign fd_rd  = ir_field(fd_ir, RD_LSB);
    assign fd_rs  = ir_field(fd_ir, RS_LSB);
    assign fd_rt  = ir_field(fd_ir, RT_LSB);
    assign dx_op  = ir_field(dx_ir, OPC_LSB);
    assign dx_rd  = ir_field(dx_ir, RD_LSB);
    assign dx_alu = ir_field(dx_ir, ALUOP_LSB);

    assign dx_rtype = (dx_op == OP_RTYPE);
    assign is_mult  = dx_rtype && (dx_alu == ALU_MULT);
    assign is_div   = dx_rtype && (dx_alu == ALU_DIV);
    assign dx_is_lw = (dx_op == OP_LW);

    // Stores, compare-branches and jr read their rd field as a source operand.
    assign fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                         (fd_op == OP_BLT) || (fd_op == OP_JR);

    assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_rs) ||
                       ((fd_op == OP_RTYPE) && (dx_rd == fd_rt)) ||
                       (fd_reads_rd && (dx_rd == fd_rd)));

    assign unused_fields = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: latch enables, bubble insertion,
// mult/div start/wait/timeout sequencing and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic             branch_taken,
    input  logic             md_ready,
    input  logic             md_exception_in,
    output logic             pc_enable,
    output logic             fd_enable,
    output logic             dx_enable,
    output logic             fd_nop_sel,
    output logic             dx_nop_sel,
    output logic             xm_nop_sel,
    output logic             md_ctrl_mult,
    output logic             md_ctrl_div,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] next_wait_cnt;
    logic              set_timeout;
    logic              is_mult;
    logic              is_div;
    logic              dx_is_lw;
    logic              load_use;
    logic              unused_inputs;

    // The div-by-zero flag travels with the result through the datapath.
    assign unused_inputs = md_exception_in;

    pipeline_hazard_ctrl_hazard_detect u_detect (
        .fd_ir    (fd_ir),
        .dx_ir    (dx_ir),
        .is_mult  (is_mult),
        .is_div   (is_div),
        .dx_is_lw (dx_is_lw),
        .load_use (load_use)
    );

    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        set_timeout   = 1'b0;
        pc_enable     = 1'b1;
        fd_enable     = 1'b1;
        dx_enable     = 1'b1;
        fd_nop_sel    = 1'b0;
        dx_nop_sel    = 1'b0;
        xm_nop_sel    = 1'b0;
        md_ctrl_mult  = 1'b0;
        md_ctrl_div   = 1'b0;
        // Outputs read as idle while reset is held, whatever sits in the latches.
        if (!reset) begin
            unique case (state)
                ST_RUN: begin
                    if (is_mult || is_div) begin
                        md_ctrl_mult  = is_mult;
                        md_ctrl_div   = is_div;
                        pc_enable     = 1'b0;
                        fd_enable     = 1'b0;
                        dx_enable     = 1'b0;
                        xm_nop_sel    = 1'b1;
                        next_state    = ST_MD_WAIT;
                        next_wait_cnt = '0;
                    end else if (branch_taken && !dx_is_lw) begin
                        fd_nop_sel = 1'b1;
                        dx_nop_sel = 1'b1;
                    end else if (load_use) begin
                        pc_enable  = 1'b0;
                        fd_enable  = 1'b0;
                        dx_nop_sel = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_ready) begin
                        next_state = ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        set_timeout = 1'b1;
                        next_state  = ST_RUN;
                    end else begin
                        pc_enable     = 1'b0;
                        fd_enable     = 1'b0;
                        dx_enable     = 1'b0;
                        xm_nop_sel    = 1'b1;
                        next_wait_cnt = wait_cnt + WAIT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            md_timeout  <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            if (set_timeout) begin
                md_timeout <= 1'b1;
            end
            if (!pc_enable && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
